// File: rtl/sync_stable_capture_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_pkg : shared state encoding and sizing helpers for sync_stable_capture
// Rev 1.0
// ------------------------------------------------------------------
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  localparam int GLITCH_CNT_W = 8;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_stable_capture_if.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_stable_capture_if : data/handshake bundle (glitchCnt with SYNC_GLITCH_COUNT_EN)
// Rev 1.0
// ------------------------------------------------------------------
interface sync_stable_capture_if
  import sync_pkg::*;
#(
  parameter int S = 8
);
  logic [S-1:0] dataIn;
  logic [S-1:0] dataOut;
  logic         dataValid;
  logic         dataReady;
  logic         overrun;
  logic         busy;
`ifdef SYNC_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] glitchCnt;
`endif

  // master: the capture block, which owns the valid side of the handshake
  modport master (
    input  dataIn,
    input  dataReady,
    output dataOut,
    output dataValid,
    output overrun,
`ifdef SYNC_GLITCH_COUNT_EN
    output glitchCnt,
`endif
    output busy
  );

  modport slave (
    output dataIn,
    output dataReady,
    input  dataOut,
    input  dataValid,
    input  overrun,
`ifdef SYNC_GLITCH_COUNT_EN
    input  glitchCnt,
`endif
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_stable_capture_stable_run_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// stable_run_counter : saturating run-length counter, done at STABLE_CYCLES-1
// Rev 1.0
// ------------------------------------------------------------------
module stable_run_counter
  import sync_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_load1,
  input  wire logic i_inc,
  output logic      o_done
);
  localparam int CW = cnt_width(STABLE_CYCLES);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load1) begin
      r_cnt <= CW'(1);
    end else if (i_inc && (r_cnt < CW'(STABLE_CYCLES))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_done = (r_cnt == CW'(STABLE_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/sync_stable_capture.sv
`default_nettype none
// ------------------------------------------------------------------
// sync_stable_capture : commits a synchronized word once stable, valid/ready out.
// Optional glitch counter enabled by SYNC_GLITCH_COUNT_EN.  Rev 1.0
// ------------------------------------------------------------------
module sync_stable_capture
  import sync_pkg::*;
#(
  parameter int S             = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sync_stable_capture_if.master  bus
);
  state_t       r_state;
  logic [S-1:0] r_cand;
  logic [S-1:0] r_out;
  logic         r_valid;
  logic         r_overrun;
  logic         r_busy;

  logic w_ne_out;
  logic w_ne_cand;
  logic w_done;
  logic w_clear;
  logic w_load1;
  logic w_inc;

  assign w_ne_out  = (bus.dataIn != r_out);
  assign w_ne_cand = (bus.dataIn != r_cand);

  // Counter controls mirror the FSM priority: abort/commit clear, new value loads 1
  assign w_clear = (r_state == SETTLE) && (!w_ne_out || (!w_ne_cand && w_done));
  assign w_load1 = ((r_state == IDLE) && w_ne_out)
                || ((r_state == SETTLE) && w_ne_out && w_ne_cand)
                || ((r_state == HOLD) && bus.dataReady && w_ne_out);
  assign w_inc   = (r_state == SETTLE) && w_ne_out && !w_ne_cand && !w_done;

  stable_run_counter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_run_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_load1 (w_load1),
    .i_inc   (w_inc),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cand    <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ne_out) begin
            r_cand  <= bus.dataIn;
            r_state <= SETTLE;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (!w_ne_out) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_ne_cand) begin
            r_cand <= bus.dataIn;
          end else if (w_done) begin
            r_out   <= r_cand;
            r_valid <= 1'b1;
            r_state <= HOLD;
            r_busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.dataReady) begin
            r_valid <= 1'b0;
            if (w_ne_out) begin
              r_cand  <= bus.dataIn;
              r_state <= SETTLE;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_ne_out) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNC_GLITCH_COUNT_EN
  logic [GLITCH_CNT_W-1:0] r_glitch;
  logic                    w_glitch;

  assign w_glitch = (r_state == SETTLE) && (!w_ne_out || w_ne_cand);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_glitch <= '0;
    end else if (w_glitch && (r_glitch != {GLITCH_CNT_W{1'b1}})) begin
      r_glitch <= r_glitch + GLITCH_CNT_W'(1);
    end
  end

  assign bus.glitchCnt = r_glitch;
`endif

  assign bus.dataOut   = r_out;
  assign bus.dataValid = r_valid;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sync_stable_capture.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sync_stable_capture : directed + randomized checks against a run-length model
// Rev 1.0
// ------------------------------------------------------------------
module tb_sync_stable_capture;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sync_stable_capture_if #(.S(8)) bus ();

  sync_stable_capture #(.S(8), .STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: committed word, pending flag, and length of the current identical run
  logic [7:0] m_out, m_cand;
  bit         m_valid, m_ovr, m_track;
  int         m_len, m_glitch;

  task automatic model_reset();
    m_out = 8'h00; m_cand = 8'h00; m_valid = 0; m_ovr = 0; m_track = 0;
    m_len = 0; m_glitch = 0;
  endtask

  task automatic model_step(input logic [7:0] din, input bit rdy);
    if (m_valid) begin
      if (rdy) begin
        m_valid = 0;
        if (din != m_out) begin m_track = 1; m_cand = din; m_len = 1; end
      end else if (din != m_out) begin
        m_ovr = 1;
      end
    end else if (m_track) begin
      if (din == m_out) begin
        m_track = 0;
        if (m_glitch < 255) m_glitch++;
      end else if (din != m_cand) begin
        m_cand = din; m_len = 1;
        if (m_glitch < 255) m_glitch++;
      end else begin
        m_len++;
        if (m_len == STABLE) begin m_out = m_cand; m_valid = 1; m_track = 0; end
      end
    end else if (din != m_out) begin
      m_track = 1; m_cand = din; m_len = 1;
    end
  endtask

  task automatic tick(input logic [7:0] din, input bit rdy);
    @(negedge clk);
    bus.dataIn    = din;
    bus.dataReady = rdy;
    @(posedge clk);
    model_step(din, rdy);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.dataIn = 8'h00; bus.dataReady = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.dataOut, bus.dataValid, bus.overrun, bus.busy} !== 11'h0) begin
      bad++;
      $display("FAIL reset_values: got out=%h v=%b o=%b b=%b want all zero",
               bus.dataOut, bus.dataValid, bus.overrun, bus.busy);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 20; i++) begin
      tick(8'h00, 1'b0);
      total++;
      if ({bus.dataOut, bus.dataValid, bus.busy} !== {8'h00, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL idle_hold[%0d]: got out=%h v=%b b=%b want 00/0/0",
                 i, bus.dataOut, bus.dataValid, bus.busy);
      end
    end
  endtask

  task automatic test_step_commit();
    int busy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(8'hA5, 1'b1);
      if (bus.busy) busy_cnt++;
      if (i == 3) begin
        total++;
        if ({bus.dataOut, bus.dataValid} !== {8'hA5, 1'b1}) begin
          bad++;
          $display("FAIL step_commit_edge4: got out=%h v=%b want a5/1", bus.dataOut, bus.dataValid);
        end
      end else if (i == 4) begin
        total++;
        if (bus.dataValid !== 1'b0) begin
          bad++;
          $display("FAIL step_accept: got v=%b want 0", bus.dataValid);
        end
      end else begin
        total++;
        if (bus.dataValid !== 1'b0) begin
          bad++;
          $display("FAIL step_early_valid[%0d]: got v=%b want 0", i, bus.dataValid);
        end
      end
    end
    total++;
    if (busy_cnt != 3) begin
      bad++;
      $display("FAIL step_busy_cycles: got %0d want 3", busy_cnt);
    end
  endtask

  task automatic test_glitch_abort();
    logic [7:0] seq [5] = '{8'h3C, 8'h3C, 8'hA5, 8'hA5, 8'hA5};
    for (int i = 0; i < 5; i++) begin
      tick(seq[i], 1'b1);
      total++;
      if ({bus.dataOut, bus.dataValid, bus.overrun, bus.busy} !== {m_out, m_valid, m_ovr, m_track}) begin
        bad++;
        $display("FAIL glitch_abort[%0d]: got out=%h v=%b o=%b b=%b want out=%h v=%b o=%b b=%b",
                 i, bus.dataOut, bus.dataValid, bus.overrun, bus.busy, m_out, m_valid, m_ovr, m_track);
      end
    end
    total++;
    if (bus.dataOut !== 8'hA5) begin
      bad++;
      $display("FAIL glitch_keep_out: got %h want a5", bus.dataOut);
    end
`ifdef SYNC_GLITCH_COUNT_EN
    total++;
    if (bus.glitchCnt !== 8'd1) begin
      bad++;
      $display("FAIL glitch_cnt_abort: got %0d want 1", bus.glitchCnt);
    end
`endif
  endtask

  task automatic test_restart();
    logic [7:0] seq [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
    int commits = 0;
    for (int i = 0; i < 9; i++) begin
      tick(seq[i], 1'b1);
      if (bus.dataValid === 1'b1) begin
        commits++;
        total++;
        if (bus.dataOut !== 8'h33) begin
          bad++;
          $display("FAIL restart_value: got %h want 33", bus.dataOut);
        end
      end
      total++;
      if ({bus.dataOut, bus.dataValid, bus.busy} !== {m_out, m_valid, m_track}) begin
        bad++;
        $display("FAIL restart_track[%0d]: got out=%h v=%b b=%b want out=%h v=%b b=%b",
                 i, bus.dataOut, bus.dataValid, bus.busy, m_out, m_valid, m_track);
      end
    end
    total++;
    if (commits != 1) begin
      bad++;
      $display("FAIL restart_commits: got %0d want 1", commits);
    end
`ifdef SYNC_GLITCH_COUNT_EN
    total++;
    if (bus.glitchCnt !== 8'd3) begin
      bad++;
      $display("FAIL glitch_cnt_restart: got %0d want 3", bus.glitchCnt);
    end
`endif
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 4; i++) tick(8'h55, 1'b0);
    total++;
    if ({bus.dataOut, bus.dataValid, bus.overrun} !== {8'h55, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ovr_commit: got out=%h v=%b o=%b want 55/1/0", bus.dataOut, bus.dataValid, bus.overrun);
    end
    for (int i = 0; i < 3; i++) tick(8'h66, 1'b0);
    total++;
    if ({bus.dataOut, bus.dataValid, bus.overrun} !== {8'h55, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ovr_flag: got out=%h v=%b o=%b want 55/1/1", bus.dataOut, bus.dataValid, bus.overrun);
    end
    for (int i = 0; i < 5; i++) begin
      tick(8'h66, 1'b1);
      total++;
      if ({bus.dataOut, bus.dataValid, bus.overrun, bus.busy} !== {m_out, m_valid, m_ovr, m_track}) begin
        bad++;
        $display("FAIL ovr_drain[%0d]: got out=%h v=%b o=%b b=%b want out=%h v=%b o=%b b=%b",
                 i, bus.dataOut, bus.dataValid, bus.overrun, bus.busy, m_out, m_valid, m_ovr, m_track);
      end
      if (i == 3) begin
        total++;
        if ({bus.dataOut, bus.dataValid, bus.overrun} !== {8'h66, 1'b1, 1'b1}) begin
          bad++;
          $display("FAIL ovr_second_commit: got out=%h v=%b o=%b want 66/1/1",
                   bus.dataOut, bus.dataValid, bus.overrun);
        end
      end
    end
  endtask

  task automatic test_reset_midsettle();
    tick(8'h77, 1'b1);
    tick(8'h77, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if ({bus.dataOut, bus.dataValid, bus.overrun, bus.busy} !== 11'h0) begin
      bad++;
      $display("FAIL async_reset: got out=%h v=%b o=%b b=%b want all zero",
               bus.dataOut, bus.dataValid, bus.overrun, bus.busy);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(8'h77, 1'b1);
      total++;
      if (bus.dataValid !== (i == 3)) begin
        bad++;
        $display("FAIL post_reset_latency[%0d]: got v=%b want %b", i, bus.dataValid, (i == 3));
      end
    end
    total++;
    if (bus.dataOut !== 8'h77) begin
      bad++;
      $display("FAIL post_reset_value: got %h want 77", bus.dataOut);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [4] = '{8'h0F, 8'hF0, 8'h81, 8'h18};
    logic [7:0] v;
    int hold;
    int n = 0;
    while (n < 400) begin
      v    = ($urandom_range(0, 2) == 0) ? m_out : pool[$urandom_range(0, 3)];
      hold = $urandom_range(1, 6);
      for (int k = 0; k < hold; k++) begin
        tick(v, ($urandom_range(0, 3) != 0));
        n++;
        total++;
        if ({bus.dataOut, bus.dataValid, bus.overrun, bus.busy} !== {m_out, m_valid, m_ovr, m_track}) begin
          bad++;
          $display("FAIL random[%0d]: got out=%h v=%b o=%b b=%b want out=%h v=%b o=%b b=%b",
                   n, bus.dataOut, bus.dataValid, bus.overrun, bus.busy, m_out, m_valid, m_ovr, m_track);
        end
`ifdef SYNC_GLITCH_COUNT_EN
        total++;
        if (bus.glitchCnt !== 8'(m_glitch)) begin
          bad++;
          $display("FAIL random_glitch[%0d]: got %0d want %0d", n, bus.glitchCnt, m_glitch);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_step_commit();
    test_glitch_abort();
    test_restart();
    test_overrun();
    test_reset_midsettle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_stable_capture.md
Name: sync_stable_capture

Overview:
- Downstream consumer of the dual-flop synchronizer output bus.
- Treats the synchronized multi-bit word as valid only after it holds the same value for STABLE_CYCLES consecutive clk samples. This filters the transient skew of individually synchronized bits.
- Commits the filtered word and presents it on a valid/ready handshake to the destination-domain logic.

Parameters:
- S, 8, data width; must match the upstream synchronizer width.
- STABLE_CYCLES, 4, consecutive identical samples required to commit; legal range 2..255.

Ports:
- clk  input  1  destination-domain clock
- rst  input  1  asynchronous active-high reset
- dataIn  input  S  synchronized word from the dual-flop synchronizer
- dataOut  output  S  last committed word, registered
- dataValid  output  1  committed word pending acceptance
- dataReady  input  1  consumer accepts dataOut when high together with dataValid
- overrun  output  1  sticky; a change arrived while a commit was unaccepted
- busy  output  1  high in SETTLE state

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset rst is asynchronous, active-high.
  - While rst is high: dataOut=0, dataValid=0, overrun=0, busy=0, candidate=0, cnt=0, state=IDLE.
- The committed value is dataOut. After reset it is 0, so a nonzero dataIn after reset starts a settle.
- Internal registers:
  - candidate[S-1:0]
  - cnt, width clog2(STABLE_CYCLES+1), saturating
  - state: IDLE / SETTLE / HOLD
- IDLE:
  - If dataIn != dataOut: candidate<=dataIn, cnt<=1, go to SETTLE.
  - Otherwise stay.
- SETTLE (busy=1), checks evaluated in this priority order:
  1. dataIn == dataOut: go to IDLE, cnt<=0. This is an aborted settle (glitch).
  2. dataIn != candidate: candidate<=dataIn, cnt<=1, stay (restart).
  3. cnt == STABLE_CYCLES-1: dataOut<=candidate, dataValid<=1, cnt<=0, go to HOLD.
  4. Otherwise: cnt<=cnt+1.
- Latency:
  - The first edge sampling a new stable value is E0.
  - dataOut and dataValid update at edge E(STABLE_CYCLES-1), i.e. after STABLE_CYCLES sampling edges in total.
- HOLD (dataValid=1):
  - dataOut is frozen.
  - On an edge with dataReady=1, dataValid<=0. In the same edge:
    - If dataIn != dataOut: candidate<=dataIn, cnt<=1, go to SETTLE.
    - Otherwise go to IDLE.
  - On an edge with dataReady=0 and dataIn != dataOut: overrun<=1 and stay in HOLD. The new value is not tracked until acceptance.
- overrun clears only on rst.
- dataReady is ignored outside HOLD. dataValid never drops without a handshake, except on rst.
- Reset mid-operation (any state): immediate return to reset values. The pending commit is discarded.
- Comparisons use full S-bit equality. There is no arithmetic on the data path.

Optional Feature:
- Macro: SYNC_GLITCH_COUNT_EN.
- Defined:
  - Adds output port glitchCnt, 8 bits.
  - glitchCnt increments on every SETTLE→IDLE abort (priority rule 1) and on every SETTLE restart (rule 2).
  - Saturates at 255. Reset value 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package sync_pkg:
  - state typedef {IDLE, SETTLE, HOLD}, 2-bit encoding 00/01/10
  - function cnt_width(STABLE_CYCLES)
  - constant GLITCH_CNT_W = 8
- One natural sub-module: stable_run_counter. It holds cnt plus the load-1, increment and terminal-compare logic, and exposes a done flag at STABLE_CYCLES-1. The FSM and handshake stay in the top.

Test Plan (S=8, STABLE_CYCLES=4):
- Reset, then hold dataIn=0x00 for 20 cycles → dataValid stays 0, busy stays 0, dataOut=0x00.
- Step dataIn 0x00→0xA5 and hold, dataReady=1 → busy=1 for 3 cycles; dataOut=0xA5 and dataValid=1 after the 4th sampling edge; dataValid=0 one cycle later.
- From committed 0xA5, drive 0x3C for 2 cycles, then 0xA5 again → no commit, dataOut stays 0xA5. With SYNC_GLITCH_COUNT_EN, glitchCnt=1.
- Drive 0x11 for 2 cycles, 0x22 for 2 cycles, then 0x33 stable → a single commit of 0x33. 0x11 and 0x22 are never presented. glitchCnt increments on the restart.
- Commit 0x55 with dataReady=0, then change dataIn to 0x66 → overrun=1 and dataOut holds 0x55. Raise dataReady → dataValid=0, then 0x66 commits 4 edges later and overrun remains 1.
- Assert rst while in SETTLE with cnt=2 → dataOut=0, dataValid=0, overrun=0, busy=0 asynchronously. After release with dataIn=0x77, the commit takes the full 4 edges.
